// File: rtl/fnd_scan_controller.sv
// Four-digit scan driver: sequential double-dabble binary-to-BCD conversion
// feeding a time-multiplexed BCD bus with active-low anode selects.
module fnd_scan_controller #(
    parameter int SCAN_DIV = 100000,
    parameter int BIN_W    = 14
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [BIN_W-1:0] i_value,
    input  logic             i_load,
    input  logic             i_blank_lz,
    output logic [3:0]       o_bcd,
    output logic [3:0]       o_an,
    output logic             o_busy,
    output logic             o_ovf
);

    localparam int               PRE_W   = $clog2(SCAN_DIV);
    localparam logic [BIN_W-1:0] MAX_VAL = BIN_W'(9999);
    localparam logic [3:0]       LAST_STEP = 4'(BIN_W - 1);

    typedef enum logic {
        S_IDLE,
        S_CONV
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [15:0]        r_bcd;
    logic [BIN_W-1:0]   r_bin;
    logic [3:0]         r_cnt;
    logic [15:0]        r_disp;
    logic               r_ovf;
    logic [PRE_W-1:0]   r_pre;
    logic [1:0]         r_idx;

    logic               w_accept;
    logic               w_last;
    logic [15:0]        w_adj;
    logic [15:0]        w_bcd_next;
    logic [BIN_W-1:0]   w_bin_next;
    logic [3:0]         w_digit;
    logic               w_lead_zero;

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_last   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_load) begin
                    w_accept = 1'b1;
                    w_next   = S_CONV;
                end
            end
            S_CONV: begin
                if (r_cnt == LAST_STEP) begin
                    w_last = 1'b1;
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // One double-dabble step: add-3 on nibbles >= 5, then shift {bcd, bin} left.
    always_comb begin
        w_adj = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            w_adj[4*i +: 4] = (r_bcd[4*i +: 4] >= 4'd5) ? r_bcd[4*i +: 4] + 4'd3
                                                        : r_bcd[4*i +: 4];
        end
        w_bcd_next = 16'({w_adj, r_bin[BIN_W-1]});
        w_bin_next = {r_bin[BIN_W-2:0], 1'b0};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bcd  <= '0;
            r_bin  <= '0;
            r_cnt  <= '0;
            r_disp <= '0;
            r_ovf  <= 1'b0;
        end else if (w_accept) begin
            r_bcd <= '0;
            r_bin <= (i_value > MAX_VAL) ? MAX_VAL : i_value;
            r_ovf <= (i_value > MAX_VAL);
            r_cnt <= '0;
        end else if (r_state == S_CONV) begin
            r_bcd <= w_bcd_next;
            r_bin <= w_bin_next;
            r_cnt <= r_cnt + 4'd1;
            if (w_last) r_disp <= w_bcd_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pre <= '0;
            r_idx <= '0;
        end else if (r_pre == PRE_W'(SCAN_DIV - 1)) begin
            r_pre <= '0;
            r_idx <= r_idx + 2'd1;
        end else begin
            r_pre <= r_pre + PRE_W'(1);
        end
    end

    always_comb begin
        o_an        = 4'b1110;
        w_lead_zero = 1'b0;
        case (r_idx)
            2'd0: o_an = 4'b1110;
            2'd1: begin
                o_an        = 4'b1101;
                w_lead_zero = (r_disp[15:4] == 12'd0);
            end
            2'd2: begin
                o_an        = 4'b1011;
                w_lead_zero = (r_disp[15:8] == 8'd0);
            end
            2'd3: begin
                o_an        = 4'b0111;
                w_lead_zero = (r_disp[15:12] == 4'd0);
            end
            default: o_an = 4'b1110;
        endcase
        w_digit = r_disp[{r_idx, 2'b00} +: 4];
        o_bcd   = (i_blank_lz && w_lead_zero) ? 4'hF : w_digit;
    end

    assign o_busy = (r_state == S_CONV);
    assign o_ovf  = r_ovf;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Self-checking bench: directed and random loads compared every cycle against
// an arithmetic model of the displayed value, scan position and busy window.
module tb_fnd_scan_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [13:0] i_value = '0;
    logic        i_load = 1'b0;
    logic        i_blank_lz = 1'b0;
    logic [3:0]  o_bcd;
    logic [3:0]  o_an;
    logic        o_busy;
    logic        o_ovf;

    int n_checks = 0;
    int n_errors = 0;

    fnd_scan_controller #(.SCAN_DIV(4), .BIN_W(14)) dut (
        .clk        (clk),
        .reset      (reset),
        .i_value    (i_value),
        .i_load     (i_load),
        .i_blank_lz (i_blank_lz),
        .o_bcd      (o_bcd),
        .o_an       (o_an),
        .o_busy     (o_busy),
        .o_ovf      (o_ovf)
    );

    always #5 clk = ~clk;

    // Model: edges since reset give the scan slot; a load schedules a commit 14 edges later.
    int m_edges = 0;
    int m_val   = 0;
    int m_pend  = 0;
    int m_busy  = 0;
    bit m_ovf   = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_edges <= 0;
            m_val   <= 0;
            m_busy  <= 0;
            m_ovf   <= 1'b0;
        end else begin
            m_edges <= m_edges + 1;
            if (m_busy != 0) begin
                m_busy <= m_busy - 1;
                if (m_busy == 1) m_val <= m_pend;
            end else if (i_load) begin
                m_pend <= (int'(i_value) > 9999) ? 9999 : int'(i_value);
                m_ovf  <= (int'(i_value) > 9999);
                m_busy <= 14;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic cyc();
        int idx;
        int pw;
        int exp_bcd;
        @(negedge clk);
        idx     = (m_edges / 4) % 4;
        pw      = (idx == 0) ? 1 : (idx == 1) ? 10 : (idx == 2) ? 100 : 1000;
        exp_bcd = (m_val / pw) % 10;
        if (i_blank_lz && idx != 0 && m_val < pw) exp_bcd = 15;
        check("an",   32'(o_an),   32'(4'hF & ~(4'd1 << idx)));
        check("bcd",  32'(o_bcd),  32'(exp_bcd));
        check("busy", 32'(o_busy), 32'(m_busy != 0));
        check("ovf",  32'(o_ovf),  32'(m_ovf));
    endtask

    task automatic load(input int v);
        i_value = 14'(v);
        i_load  = 1'b1;
        cyc();
        i_load  = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) cyc();
        reset = 1'b0;
        repeat (20) cyc();

        load(1234);           repeat (34) cyc();
        load(10000);          repeat (34) cyc();
        load(42);             repeat (34) cyc();
        i_blank_lz = 1'b1;
        load(7);              repeat (22) cyc();
        i_blank_lz = 1'b0;    repeat (8) cyc();
        i_blank_lz = 1'b1;
        load(0);              repeat (34) cyc();
        load(1005);           repeat (34) cyc();
        i_blank_lz = 1'b0;

        load(1234);
        repeat (4) cyc();
        load(5678);           repeat (30) cyc();
        load(5678);           repeat (34) cyc();

        load(9999);
        repeat (6) cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        repeat (40) cyc();

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 49) == 0) i_blank_lz = ~i_blank_lz;
            reset = ($urandom_range(0, 499) == 0);
            i_load = ($urandom_range(0, 15) == 0);
            case ($urandom_range(0, 3))
                0:       i_value = 14'($urandom_range(0, 9));
                1:       i_value = 14'($urandom_range(9990, 16383));
                2:       i_value = 14'($urandom_range(0, 120));
                default: i_value = 14'($urandom_range(0, 9999));
            endcase
            cyc();
        end
        reset  = 1'b0;
        i_load = 1'b0;
        repeat (20) cyc();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
